// File: rtl/mux_pkg.sv
// Shared definitions for the N:1 scanning multiplexer.
//   mux_state_e : controller state (IDLE / MAN / SCN)
//   MODE_*      : encodings of the mode input
package mux_pkg;

    typedef enum logic [1:0] {IDLE, MAN, SCN} mux_state_e;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_scan_ctr.sv
// Channel / dwell counter for the auto-scan mode.
//   clk, rst : clock, asynchronous active-high reset
//   inc      : advance one scan step this cycle
//   restart  : treat the counters as zero for this step (scan restarts at channel 0)
//   ch       : channel to sample this cycle
//   last     : this step is the final dwell cycle of channel N-1
module mux_scan_ctr
    import mux_pkg::*;
#(
    parameter int N     = 8,
    parameter int DWELL = 1,
    parameter int SW    = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          restart,
    output logic [SW-1:0] ch,
    output logic          last
);

    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;

    logic [SW-1:0] ch_cnt;
    logic [DW-1:0] dwell_cnt;
    logic [SW-1:0] cur_ch;
    logic [DW-1:0] cur_dw;
    logic          last_dw;

    // restart acts on the same edge as the first sample, so the sampled
    // channel is forced to 0 combinationally rather than a cycle later.
    always_comb begin
        cur_ch  = restart ? '0 : ch_cnt;
        cur_dw  = restart ? '0 : dwell_cnt;
        last_dw = (cur_dw == DW'(DWELL - 1));
        ch      = cur_ch;
        last    = last_dw && (cur_ch == SW'(N - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_cnt    <= '0;
            dwell_cnt <= '0;
        end else if (inc) begin
            if (last_dw) begin
                dwell_cnt <= '0;
                ch_cnt    <= (cur_ch == SW'(N - 1)) ? '0 : cur_ch + SW'(1);
            end else begin
                dwell_cnt <= cur_dw + DW'(1);
                ch_cnt    <= cur_ch;
            end
        end else if (restart) begin
            ch_cnt    <= '0;
            dwell_cnt <= '0;
        end
    end

endmodule

// File: rtl/mux_scan_n.sv
// Registered N:1 multiplexer with manual select and round-robin auto-scan.
//   clk, rst : clock, asynchronous active-high reset
//   en       : sample enable (0 -> IDLE, outputs hold, counters frozen)
//   mode     : 0 manual (sel chooses channel), 1 auto-scan
//   sel      : manual channel select
//   d        : packed channel data, channel k = d[k*W +: W]
//   y, y_ch  : registered sample and the channel it came from
//   y_vld    : y/y_ch carry a fresh valid sample
//   wrap     : pulse with the last dwell sample of channel N-1 in scan mode
module mux_scan_n
    import mux_pkg::*;
#(
    parameter int N     = 8,
    parameter int W     = 1,
    parameter int DWELL = 1,
    parameter int SW    = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           mode,
    input  logic [SW-1:0]  sel,
    input  logic [N*W-1:0] d,
    output logic [W-1:0]   y,
    output logic [SW-1:0]  y_ch,
    output logic           y_vld,
    output logic           wrap
);

    localparam logic [SW:0] N_LIM = (SW + 1)'(N);

    mux_state_e    state;
    mux_state_e    nxt_state;
    logic          was_scn;
    logic          scan_go;
    logic          restart;
    logic          man_ok;
    logic [SW-1:0] scan_ch;
    logic          scan_last;
    logic [W-1:0]  man_data;
    logic [W-1:0]  scan_data;

    // Loop-based selection keeps out-of-range indices (non-power-of-2 N)
    // from ever addressing past the packed input vector.
    function automatic logic [W-1:0] pick(input logic [N*W-1:0] din,
                                          input logic [SW-1:0]  idx);
        logic [W-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) begin
            if (idx == SW'(k)) r = din[k*W +: W];
        end
        return r;
    endfunction

    always_comb begin
        nxt_state = IDLE;
        if (en) nxt_state = (mode == MODE_SCAN) ? SCN : MAN;
        scan_go   = (nxt_state == SCN);
        // Resume only when the last active state was SCN (directly or via IDLE).
        restart   = scan_go && !((state == SCN) || ((state == IDLE) && was_scn));
        man_ok    = ({1'b0, sel} < N_LIM);
        man_data  = pick(d, sel);
        scan_data = pick(d, scan_ch);
    end

    mux_scan_ctr #(
        .N     (N),
        .DWELL (DWELL),
        .SW    (SW)
    ) u_ctr (
        .clk     (clk),
        .rst     (rst),
        .inc     (scan_go),
        .restart (restart),
        .ch      (scan_ch),
        .last    (scan_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            was_scn <= 1'b0;
            y       <= '0;
            y_ch    <= '0;
            y_vld   <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            state <= nxt_state;
            case (nxt_state)
                MAN: begin
                    y       <= man_ok ? man_data : '0;
                    y_ch    <= sel;
                    y_vld   <= man_ok;
                    wrap    <= 1'b0;
                    was_scn <= 1'b0;
                end
                SCN: begin
                    y       <= scan_data;
                    y_ch    <= scan_ch;
                    y_vld   <= 1'b1;
                    wrap    <= scan_last;
                    was_scn <= 1'b1;
                end
                default: begin
                    y_vld <= 1'b0;
                    wrap  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan_n.sv
// Bench for mux_scan_n: one 8x1-bit DWELL=1 instance and one 5x4-bit DWELL=3 instance.
module tb_mux_scan_n;

    typedef struct packed {
        logic [3:0] y;
        logic [2:0] ch;
        logic       vld;
        logic       wrap;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_a, mode_a, en_b, mode_b;
    logic [2:0]  sel_a, sel_b;
    logic [7:0]  d_a;
    logic [19:0] d_b;
    logic [0:0]  y_a;
    logic [3:0]  y_b;
    logic [2:0]  ych_a, ych_b;
    logic        vld_a, vld_b, wrap_a, wrap_b;

    exp_t qa[$];
    exp_t qb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    mux_scan_n #(.N(8), .W(1), .DWELL(1)) dut_a (
        .clk(clk), .rst(rst), .en(en_a), .mode(mode_a), .sel(sel_a), .d(d_a),
        .y(y_a), .y_ch(ych_a), .y_vld(vld_a), .wrap(wrap_a)
    );

    mux_scan_n #(.N(5), .W(4), .DWELL(3)) dut_b (
        .clk(clk), .rst(rst), .en(en_b), .mode(mode_b), .sel(sel_b), .d(d_b),
        .y(y_b), .y_ch(ych_b), .y_vld(vld_b), .wrap(wrap_b)
    );

    task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_chk++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_a(input string tag);
        exp_t e;
        e = qa.pop_front();
        cmp({tag, ".y"},    8'(y_a),    8'(e.y));
        cmp({tag, ".ch"},   8'(ych_a),  8'(e.ch));
        cmp({tag, ".vld"},  8'(vld_a),  8'(e.vld));
        cmp({tag, ".wrap"}, 8'(wrap_a), 8'(e.wrap));
    endtask

    task automatic chk_b(input string tag);
        exp_t e;
        e = qb.pop_front();
        cmp({tag, ".y"},    8'(y_b),    8'(e.y));
        cmp({tag, ".ch"},   8'(ych_b),  8'(e.ch));
        cmp({tag, ".vld"},  8'(vld_b),  8'(e.vld));
        cmp({tag, ".wrap"}, 8'(wrap_b), 8'(e.wrap));
    endtask

    task automatic cyc_a(input logic en, input logic mode, input logic [2:0] sel,
                         input logic [7:0] d, input logic [3:0] ey, input logic [2:0] ech,
                         input logic ev, input logic ew, input string tag);
        en_a = en; mode_a = mode; sel_a = sel; d_a = d;
        qa.push_back(exp_t'{y: ey, ch: ech, vld: ev, wrap: ew});
        @(posedge clk);
        #1;
        chk_a(tag);
    endtask

    task automatic cyc_b(input logic en, input logic mode, input logic [2:0] sel,
                         input logic [19:0] d, input logic [3:0] ey, input logic [2:0] ech,
                         input logic ev, input logic ew, input string tag);
        en_b = en; mode_b = mode; sel_b = sel; d_b = d;
        qb.push_back(exp_t'{y: ey, ch: ech, vld: ev, wrap: ew});
        @(posedge clk);
        #1;
        chk_b(tag);
    endtask

    task automatic chk_zero(input string tag);
        cmp({tag, ".a.y"},    8'(y_a),    8'h0);
        cmp({tag, ".a.ch"},   8'(ych_a),  8'h0);
        cmp({tag, ".a.vld"},  8'(vld_a),  8'h0);
        cmp({tag, ".a.wrap"}, 8'(wrap_a), 8'h0);
        cmp({tag, ".b.y"},    8'(y_b),    8'h0);
        cmp({tag, ".b.vld"},  8'(vld_b),  8'h0);
    endtask

    initial begin
        logic [7:0]  da;
        logic [7:0]  dra;
        logic [19:0] db;
        logic [19:0] drb;
        logic [2:0]  s;
        int          c;

        rst = 1'b1;
        en_a = 1'b0; mode_a = 1'b0; sel_a = '0; d_a = '0;
        en_b = 1'b0; mode_b = 1'b0; sel_b = '0; d_b = '0;
        @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;

        // Manual sweep over 0xAA: y follows bit sel of d.
        da = 8'hAA;
        for (int k = 0; k < 8; k++)
            cyc_a(1'b1, 1'b0, 3'(k), da, 4'(da[k]), 3'(k), 1'b1, 1'b0, "man_sweep");

        // Manual with data changing every cycle.
        for (int k = 0; k < 8; k++) begin
            dra = 8'($urandom);
            s   = 3'($urandom_range(0, 7));
            cyc_a(1'b1, 1'b0, s, dra, 4'(dra[s]), s, 1'b1, 1'b0, "man_rand");
        end

        // Asynchronous reset mid-operation, observed before the next edge.
        cyc_a(1'b1, 1'b0, 3'd7, da, 4'd1, 3'd7, 1'b1, 1'b0, "pre_rst");
        rst = 1'b1;
        #1;
        chk_zero("mid_rst");
        #1;
        rst = 1'b0;

        // Scan, DWELL=1: two full passes, wrap with every channel-7 sample.
        for (int i = 0; i < 16; i++)
            cyc_a(1'b1, 1'b1, 3'd0, da, 4'(da[i % 8]), 3'(i % 8), 1'b1,
                  (i % 8) == 7, "scan_a");
        cyc_a(1'b0, 1'b1, 3'd0, da, 4'(da[7]), 3'd7, 1'b0, 1'b0, "idle_a");

        // Scan, N=5 DWELL=3: A,A,A,B,B,B,...,E,E,E then restart at A.
        db = 20'hEDCBA;
        for (int i = 0; i < 25; i++) begin
            c = (i / 3) % 5;
            cyc_b(1'b1, 1'b1, 3'd0, db, 4'hA + 4'(c), 3'(c), 1'b1,
                  (i % 15) == 14, "scan_b");
        end
        // en dropped at channel 3 after its first dwell sample: hold.
        for (int k = 0; k < 4; k++)
            cyc_b(1'b0, 1'b1, 3'd0, db, 4'hD, 3'd3, 1'b0, 1'b0, "gap_b");
        // Resume with the remaining two dwell cycles of channel 3.
        for (int i = 25; i < 32; i++) begin
            c = (i / 3) % 5;
            cyc_b(1'b1, 1'b1, 3'd0, db, 4'hA + 4'(c), 3'(c), 1'b1,
                  (i % 15) == 14, "resume_b");
        end

        // Out-of-range manual select, then the top valid channel.
        cyc_b(1'b1, 1'b0, 3'd6, db, 4'h0, 3'd6, 1'b0, 1'b0, "man_oor");
        cyc_b(1'b1, 1'b0, 3'd4, db, 4'hE, 3'd4, 1'b1, 1'b0, "man_top");

        // MAN -> SCN restarts at channel 0 with a full dwell.
        for (int i = 0; i < 4; i++)
            cyc_b(1'b1, 1'b1, 3'd0, db, 4'hA + 4'(i / 3), 3'(i / 3), 1'b1, 1'b0, "restart_man");

        // MAN -> IDLE -> SCN also restarts.
        cyc_b(1'b1, 1'b0, 3'd2, db, 4'hC, 3'd2, 1'b1, 1'b0, "man_mid");
        cyc_b(1'b0, 1'b0, 3'd2, db, 4'hC, 3'd2, 1'b0, 1'b0, "idle_man");
        for (int i = 0; i < 3; i++)
            cyc_b(1'b1, 1'b1, 3'd0, db, 4'hA, 3'd0, 1'b1, 1'b0, "restart_idle");

        // SCN -> IDLE -> SCN resumes; data changes every cycle.
        cyc_b(1'b0, 1'b1, 3'd0, db, 4'hA, 3'd0, 1'b0, 1'b0, "idle_scn");
        for (int i = 0; i < 3; i++) begin
            drb = 20'($urandom);
            cyc_b(1'b1, 1'b1, 3'd0, drb, drb[7:4], 3'd1, 1'b1, 1'b0, "resume_rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mux_scan_n.md
Name: mux_scan_n

Overview:
- Parametrised, registered N:1 multiplexer with W-bit channels. Successor to the fixed 8:1 combinational mux.
- Adds two select modes:
  - Manual: external select.
  - Auto-scan: round-robin over all channels, holding each channel for DWELL cycles.
- Output is tagged with the channel index and a valid strobe, plus a pass-complete pulse.
- Used as a time-division front end feeding a single downstream consumer (e.g. a serializer or a logger).

Parameters:
- N, 8, number of input channels (N >= 2, need not be a power of 2)
- W, 1, bits per channel
- DWELL, 1, cycles spent on each channel in scan mode (DWELL >= 1)
- SW, $clog2(N), select/index width (derived; do not override)

Ports:
- clk    in   1     rising-edge clock
- rst    in   1     asynchronous, active-high reset
- en     in   1     advance/sample enable
- mode   in   1     0 = MANUAL, 1 = SCAN
- sel    in   SW    channel select, used in MANUAL only
- d      in   N*W   packed inputs; channel k = d[k*W +: W]
- y      out  W     registered selected data
- y_ch   out  SW    channel index that produced y
- y_vld  out  1     y/y_ch valid this cycle
- wrap   out  1     one-cycle pulse, in SCAN only, when the channel N-1 sample is output

Behaviour:
- Reset (asynchronous, on rst high): y=0, y_ch=0, y_vld=0, wrap=0, ch_cnt=0, dwell_cnt=0, state=IDLE.
- Latency: 1 cycle. Inputs sampled at edge t appear on the outputs after edge t.
- States:
  - IDLE: entered from reset, and whenever en=0. Outputs hold their last y/y_ch; y_vld=0; wrap=0; counters frozen.
  - MAN: en=1 and mode=0.
  - SCN: en=1 and mode=1.
- Transitions are evaluated every cycle from (en, mode).
  - Any transition into SCN from MAN, or from IDLE when the previous active state was not SCN, loads ch_cnt=0 and dwell_cnt=0. The scan restarts at channel 0.
  - IDLE reached from SCN and then returning to SCN resumes at the frozen ch_cnt/dwell_cnt; no restart.
- MAN:
  - sel < N: y <= d[sel], y_ch <= sel, y_vld <= 1.
  - sel >= N (non-power-of-2 N only): y <= 0, y_ch <= sel, y_vld <= 0.
  - wrap = 0.
- SCN:
  - Every en=1 cycle: y <= d[ch_cnt], y_ch <= ch_cnt, y_vld <= 1.
  - dwell_cnt increments. When dwell_cnt == DWELL-1, it clears and ch_cnt advances.
  - ch_cnt wraps N-1 -> 0, never reaching values >= N.
  - wrap <= 1 on the same edge that outputs the last dwell sample of channel N-1. Otherwise wrap <= 0.
- DWELL=1 means a new channel on every enabled cycle; a full pass takes N*DWELL cycles.
- Inputs d may change every cycle. y reflects d at the sampling edge only; there is no hold of input data.
- Mode change in the middle of a dwell takes effect on the next edge. Partial dwell progress is discarded.
- rst asserted mid-pass: all outputs and counters clear immediately (asynchronous). The first post-reset SCN cycle outputs channel 0.

Decomposition:
- Package mux_pkg:
  - typedef enum logic [1:0] {IDLE, MAN, SCN} mux_state_e
  - localparam MODE_MANUAL=1'b0, MODE_SCAN=1'b1
- Sub-module mux_scan_ctr (params N, DWELL):
  - Inputs: clk, rst, inc, restart.
  - Outputs: ch[SW-1:0], last (high on the final dwell cycle of channel N-1).
- The top level holds the FSM, the output registers and the indexed-part-select datapath.

Test Plan:
- Reset: assert rst mid-operation with y=1, y_vld=1 -> y=0, y_ch=0, y_vld=0, wrap=0 before the next clk edge.
- MAN sweep, N=8, W=1, d=8'b1010_1010, sel=0..7, one per cycle -> one cycle later y = 0,1,0,1,0,1,0,1; y_ch matches sel; y_vld=1.
- SCN, DWELL=1, same d, 16 enabled cycles -> y_ch = 0..7,0..7; y alternates 0,1; wrap=1 exactly on the y_ch=7 cycles (cycles 8 and 16).
- SCN, DWELL=3, N=5, W=4, d={4'hE,4'hD,4'hC,4'hB,4'hA} -> y = A,A,A,B,B,B,...,E,E,E; wrap=1 only on the third E; then restarts at A.
- en gaps and mode switch:
  - SCN, drop en for 4 cycles at y_ch=3 -> y_vld=0 and y/y_ch hold; resumes at ch 3 with the remaining dwell.
  - Switch to MAN with sel=6, then back to SCN -> the scan restarts at ch 0.
- Out-of-range select, N=5, MAN, sel=6 -> y=0, y_ch=6, y_vld=0; sel=4 on the next cycle -> y=d[4], y_vld=1.
